wb_rr_arbiter: RTL

- Two-master, one-slave Wishbone B4 classic/registered-burst arbiter.
- Lets the SPI bridge and the levenshtein controller share the SRAM spi_controller slave port.
- Round-robin grant, held for the whole bus cycle (cyc_i high); grant registered, slave-side signals muxed from registered grant.
- Sits between the masters and the slave-side decode.

---
 rtl/wb_rr_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone B4 round-robin arbiter; grant held for the whole bus cycle.
// Optional watchdog on stalled slaves: define WB_RR_ARBITER_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 8
`ifdef WB_RR_ARBITER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic [1:0]            grant_o
);

  // State encoding doubles as the one-hot grant, so grant_o is the FSM state.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       own0, own1;
  logic       req0, req1;
  logic       owner_stb;
  logic       hit;

  assign own0      = (state_q == GNT0);
  assign own1      = (state_q == GNT1);
  assign owner_stb = (own0 & m0_cyc_i & m0_stb_i) | (own1 & m1_cyc_i & m1_stb_i);

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       blocked_q, blocked_d;
  logic             term;

  assign term = s_ack_i | s_err_i | s_rty_i;
  assign hit  = owner_stb & ~term & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign req0 = m0_cyc_i & ~blocked_q[0];
  assign req1 = m1_cyc_i & ~blocked_q[1];

  // A timed-out master stays locked out until its cyc is seen low.
  assign blocked_d[0] = (blocked_q[0] & m0_cyc_i) | (hit & own0);
  assign blocked_d[1] = (blocked_q[1] & m1_cyc_i) | (hit & own1);

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || term) cnt_d = '0;
    else if (owner_stb)               cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      blocked_q <= 2'b00;
    end else begin
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
    end
  end
`else
  assign hit  = 1'b0;
  assign req0 = m0_cyc_i;
  assign req1 = m1_cyc_i;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = req1 ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = req0 ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (hit) begin
      state_d = IDLE;
      last_d  = own1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign grant_o = state_q;

  // Handshake: a beat is offered while cyc&stb are high and completes when the slave
  // returns ack/err/rty; terminations only reach the owner while it is strobing.
  assign s_cyc_o = ~hit & ((own0 & m0_cyc_i) | (own1 & m1_cyc_i));
  assign s_stb_o = ~hit & owner_stb;

  always_comb begin
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    if (own0) begin
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end else if (own1) begin
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end
  end

  assign m0_ack_o = own0 & m0_cyc_i & m0_stb_i & s_ack_i;
  assign m0_err_o = own0 & m0_cyc_i & m0_stb_i & (s_err_i | hit);
  assign m0_rty_o = own0 & m0_cyc_i & m0_stb_i & s_rty_i;
  assign m0_dat_o = own0 ? s_dat_i : '0;

  assign m1_ack_o = own1 & m1_cyc_i & m1_stb_i & s_ack_i;
  assign m1_err_o = own1 & m1_cyc_i & m1_stb_i & (s_err_i | hit);
  assign m1_rty_o = own1 & m1_cyc_i & m1_stb_i & s_rty_i;
  assign m1_dat_o = own1 ? s_dat_i : '0;

endmodule
